// File: rtl/sti_stream_tx.sv
// Parallel-to-serial stream transmitter: DEPTH-entry word queue feeding a
// frame shifter that serialises DW/2..2*DW-bit frames under so_ready backpressure.
module sti_stream_tx #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          pi_data,
  input  logic                   load,
  output logic                   pi_ready,
  input  logic                   pi_end,
  input  logic [1:0]             pi_length,
  input  logic                   pi_low,
  input  logic                   pi_msb,
  input  logic                   pi_fill,
  input  logic                   so_ready,
  output logic                   so_data,
  output logic                   so_valid,
  output logic                   so_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = 2 * DW;
  localparam int CW = $clog2(FW);
  localparam int HW = DW / 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [DW-1:0] r_q_data [DEPTH];
  logic [5:0]    r_q_ctrl [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  state_t        r_state;
  logic [FW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_msb;
  logic          r_end;
  logic          r_valid;
  logic          r_done;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_head_data;
  logic [5:0]    w_head_ctrl;
  logic [1:0]    w_head_len;
  logic          w_head_low;
  logic          w_head_msb;
  logic          w_head_fill;
  logic          w_head_end;
  logic [FW-1:0] w_raw;
  logic [FW-1:0] w_frame;
  logic [CW-1:0] w_len_m1;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_push      = load && !w_full;
  assign w_head_data = r_q_data[r_rd];
  assign w_head_ctrl = r_q_ctrl[r_rd];
  assign w_head_len  = w_head_ctrl[5:4];
  assign w_head_low  = w_head_ctrl[3];
  assign w_head_msb  = w_head_ctrl[2];
  assign w_head_fill = w_head_ctrl[1];
  assign w_head_end  = w_head_ctrl[0];

  // Pop when idle, or on the last bit of a non-final frame so frames run back to back.
  assign w_pop = (r_count != '0) &&
                 ((r_state == IDLE) ||
                  ((r_state == SHIFT) && so_ready && (r_cnt == '0) && !r_end));

  always_comb begin
    w_raw    = '0;
    w_len_m1 = '0;
    case (w_head_len)
      2'd0: begin
        w_raw    = FW'(w_head_low ? w_head_data[HW-1:0] : w_head_data[DW-1:HW]);
        w_len_m1 = CW'(HW - 1);
      end
      2'd1: begin
        w_raw    = FW'(w_head_data);
        w_len_m1 = CW'(DW - 1);
      end
      2'd2: begin
        w_raw    = w_head_fill ? (FW'(w_head_data) << HW) : FW'(w_head_data);
        w_len_m1 = CW'(DW + HW - 1);
      end
      default: begin
        w_raw    = w_head_fill ? (FW'(w_head_data) << DW) : FW'(w_head_data);
        w_len_m1 = CW'(FW - 1);
      end
    endcase
    // MSB-first frames are left-aligned so the shifter always emits from bit FW-1.
    w_frame = w_head_msb ? (w_raw << (CW'(FW - 1) - w_len_m1)) : w_raw;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr] <= pi_data;
      r_q_ctrl[r_wr] <= {pi_length, pi_low, pi_msb, pi_fill, pi_end};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
      r_end   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_frame;
            r_cnt   <= w_len_m1;
            r_msb   <= w_head_msb;
            r_end   <= w_head_end;
            r_valid <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (so_ready) begin
            if (r_cnt == '0) begin
              if (r_end) begin
                r_shift <= '0;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else if (w_pop) begin
                r_shift <= w_frame;
                r_cnt   <= w_len_m1;
                r_msb   <= w_head_msb;
                r_end   <= w_head_end;
              end else begin
                r_shift <= '0;
                r_valid <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_cnt   <= r_cnt - CW'(1);
              r_shift <= r_msb ? (r_shift << 1) : (r_shift >> 1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign so_data    = r_msb ? r_shift[FW-1] : r_shift[0];
  assign so_valid   = r_valid;
  assign so_done    = r_done;
  assign pi_ready   = !w_full;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_sti_stream_tx.sv
// Bench for sti_stream_tx: directed frames plus randomized traffic checked
// against a bit-stream reference built from the framing rules at push time.
module tb_sti_stream_tx;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [DW-1:0]          pi_data = '0;
  logic                   load = 1'b0;
  logic                   pi_ready;
  logic                   pi_end = 1'b0;
  logic [1:0]             pi_length = '0;
  logic                   pi_low = 1'b0;
  logic                   pi_msb = 1'b0;
  logic                   pi_fill = 1'b0;
  logic                   so_ready = 1'b0;
  logic                   so_data;
  logic                   so_valid;
  logic                   so_done;
  logic [$clog2(DEPTH):0] fifo_count;

  int total = 0;
  int bad   = 0;

  bit exp_bits[$];
  bit exp_last[$];
  bit done_pend = 1'b0;
  int cyc_no  = 0;
  int nx      = 0;
  int first_x = -1;
  int last_x  = -1;
  logic [63:0] cap = '0;

  sti_stream_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pi_data(pi_data), .load(load), .pi_ready(pi_ready),
    .pi_end(pi_end), .pi_length(pi_length), .pi_low(pi_low), .pi_msb(pi_msb),
    .pi_fill(pi_fill), .so_ready(so_ready), .so_data(so_data), .so_valid(so_valid),
    .so_done(so_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial bits of one accepted word, derived from the framing rules.
  function automatic void model_push(input logic [DW-1:0] d, input logic [1:0] len,
                                     input logic low, input logic msb,
                                     input logic fill, input logic fend);
    int unsigned L;
    int unsigned idx;
    longint unsigned f;
    longint unsigned dd;
    dd = 64'(d);
    case (len)
      2'd0:    begin L = DW / 2;     f = low ? (dd % (64'd1 << (DW / 2))) : (dd / (64'd1 << (DW / 2))); end
      2'd1:    begin L = DW;         f = dd; end
      2'd2:    begin L = 3 * DW / 2; f = fill ? dd * (64'd1 << (L - DW)) : dd; end
      default: begin L = 2 * DW;     f = fill ? dd * (64'd1 << (L - DW)) : dd; end
    endcase
    for (int unsigned k = 0; k < L; k++) begin
      idx = msb ? (L - 1 - k) : k;
      exp_bits.push_back(1'((f >> idx) & 64'd1));
      exp_last.push_back(fend && (k == L - 1));
    end
  endfunction

  // One clock: check outputs just before the edge, update the model, advance.
  task automatic cyc();
    bit nd;
    bit eb;
    nd = 1'b0;
    if (done_pend) begin
      chk("done_pulse", 64'(so_done), 64'd1);
      chk("done_valid_low", 64'(so_valid), 64'd0);
    end else begin
      chk("done_idle", 64'(so_done), 64'd0);
    end
    if (so_valid === 1'b1 && so_ready) begin
      nx++;
      cap = {cap[62:0], so_data};
      if (first_x < 0) first_x = cyc_no;
      last_x = cyc_no;
      chk("bit_expected", 64'(exp_bits.size() != 0), 64'd1);
      if (exp_bits.size() != 0) begin
        eb = exp_bits.pop_front();
        nd = exp_last.pop_front();
        chk("bit", 64'(so_data), 64'(eb));
      end
    end
    if (load && pi_ready === 1'b1)
      model_push(pi_data, pi_length, pi_low, pi_msb, pi_fill, pi_end);
    @(posedge clk);
    done_pend = nd;
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] len, input logic low,
                      input logic msb, input logic fill, input logic fend);
    pi_data = d; pi_length = len; pi_low = low; pi_msb = msb; pi_fill = fill; pi_end = fend;
    load = 1'b1;
    cyc();
    load = 1'b0;
    pi_data = DW'($urandom); pi_length = 2'($urandom); pi_low = 1'($urandom);
    pi_msb = 1'($urandom); pi_fill = 1'($urandom); pi_end = 1'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    so_ready = 1'b1;
    while ((exp_bits.size() != 0 || so_valid === 1'b1 || done_pend) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_empty", 64'(exp_bits.size()), 64'd0);
    chk("drain_idle", 64'(so_valid), 64'd0);
  endtask

  task automatic clear_run();
    nx = 0; first_x = -1; last_x = -1; cap = '0;
  endtask

  initial begin
    int acc;
    int n;
    logic rec;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(so_valid), 64'd0);
    chk("rst_data", 64'(so_data), 64'd0);
    chk("rst_done", 64'(so_done), 64'd0);
    chk("rst_ready", 64'(pi_ready), 64'd1);
    chk("rst_count", 64'(fifo_count), 64'd0);
    reset = 1'b1;

    // Single len1 MSB-first word: latency and bit order
    so_ready = 1'b1;
    clear_run();
    send(16'hA5C3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_lat0", 64'(so_valid), 64'd0);
    cyc();
    chk("t1_lat1", 64'(so_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t1_valid", 64'(so_valid), 64'd1);
      cyc();
    end
    chk("t1_after", 64'(so_valid), 64'd0);
    chk("t1_bits", 64'(cap[15:0]), 64'h0000_0000_0000_A5C3);
    chk("t1_count", 64'(nx), 64'd16);

    // Half-word frames
    clear_run();
    send(16'h12F0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(100);
    chk("t2a_bits", 64'(cap[7:0]), 64'h0F);
    chk("t2a_count", 64'(nx), 64'd8);
    clear_run();
    send(16'h12F0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(100);
    chk("t2b_bits", 64'(cap[7:0]), 64'h12);
    chk("t2b_count", 64'(nx), 64'd8);

    // Padded frames
    clear_run();
    send(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(100);
    chk("t3_bits", 64'(cap[31:0]), 64'h0000_FFFF);
    chk("t3_count", 64'(nx), 64'd32);
    clear_run();
    send(16'h0001, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(100);
    chk("t4_bits", 64'(cap[23:0]), 64'h00_8000);
    chk("t4_count", 64'(nx), 64'd24);

    // Backpressure and capacity
    so_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      pi_data = DW'($urandom); pi_length = 2'd1; pi_msb = 1'($urandom);
      pi_low = 1'($urandom); pi_fill = 1'($urandom); pi_end = 1'b0;
      load = 1'b1;
      if (pi_ready === 1'b1) acc++;
      cyc();
    end
    load = 1'b0;
    chk("t5_accepted", 64'(acc), 64'd5);
    chk("t5_count", 64'(fifo_count), 64'd4);
    chk("t5_ready", 64'(pi_ready), 64'd0);
    chk("t5_valid", 64'(so_valid), 64'd1);
    rec = so_data;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_hold", 64'(so_data), 64'(rec));
    end
    clear_run();
    so_ready = 1'b1;
    n = 0;
    while (nx < 80 && n < 300) begin cyc(); n++; end
    chk("t5_bits", 64'(nx), 64'd80);
    chk("t5_span", 64'(last_x - first_x + 1), 64'd80);
    drain(50);

    // Back-to-back frames ending a stream
    clear_run();
    for (int i = 0; i < 3; i++) begin
      pi_data = DW'($urandom); pi_length = 2'd1; pi_msb = 1'($urandom);
      pi_low = 1'($urandom); pi_fill = 1'($urandom); pi_end = (i == 2);
      load = 1'b1;
      cyc();
    end
    load = 1'b0; pi_end = 1'b0;
    n = 0;
    while (nx < 48 && n < 200) begin cyc(); n++; end
    chk("t6_bits", 64'(nx), 64'd48);
    chk("t6_span", 64'(last_x - first_x + 1), 64'd48);
    chk("t6_done", 64'(so_done), 64'd1);
    cyc();
    chk("t6_done_once", 64'(so_done), 64'd0);
    drain(50);

    // Reset mid-frame with words queued
    clear_run();
    for (int i = 0; i < 3; i++) begin
      pi_data = DW'($urandom); pi_length = 2'd3; pi_msb = 1'($urandom);
      pi_low = 1'($urandom); pi_fill = 1'($urandom); pi_end = 1'b0;
      load = 1'b1;
      cyc();
    end
    load = 1'b0;
    n = 0;
    while (nx < 7 && n < 100) begin cyc(); n++; end
    chk("t7_pre_bits", 64'(nx), 64'd7);
    chk("t7_pre_count", 64'(fifo_count), 64'd2);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_bits.delete(); exp_last.delete(); done_pend = 1'b0;
    chk("t7_valid", 64'(so_valid), 64'd0);
    chk("t7_count", 64'(fifo_count), 64'd0);
    chk("t7_ready", 64'(pi_ready), 64'd1);
    chk("t7_done", 64'(so_done), 64'd0);
    reset = 1'b1;
    clear_run();
    repeat (60) cyc();
    chk("t7_resid", 64'(nx), 64'd0);

    // Randomized traffic with random backpressure and stream ends
    for (int c = 0; c < 4000; c++) begin
      so_ready  = ($urandom_range(0, 3) != 0);
      load      = 1'($urandom_range(0, 1));
      pi_data   = DW'($urandom);
      pi_length = 2'($urandom);
      pi_low    = 1'($urandom);
      pi_msb    = 1'($urandom);
      pi_fill   = 1'($urandom);
      pi_end    = ($urandom_range(0, 4) == 0);
      cyc();
    end
    load = 1'b0;
    drain(20000);
    chk("final_count", 64'(fifo_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
